// File: rtl/fifo_pkg.sv
// Shared types for the paired-lane stream source: lane select, completion FSM states,
// and the FIFO pointer-width helper (address bits plus one wrap bit).
package fifo_pkg;

  typedef enum logic {
    LANE_1 = 1'b0,
    LANE_2 = 1'b1
  } lane_t;

  typedef logic [1:0] done_state_t;

  localparam done_state_t WAIT_BOTH = 2'd0;
  localparam done_state_t DONE1     = 2'd1;
  localparam done_state_t DONE2     = 2'd2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_pair_stream_src_if.sv
// Handshake bundle: one interleaved upstream stream in, two operand lanes out.
// slave is the block's view, master is the surrounding environment's view.
interface fifo_pair_stream_src_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] data_o1;
  logic [WIDTH-1:0] data_o2;
  logic             valid_o1;
  logic             valid_o2;
  logic             ready_1;
  logic             ready_2;
  logic             last_o1;
  logic             last_o2;
  logic             pkt_done_o;

  modport slave (
    input  data_in, valid_in, ready_1, ready_2,
    output ready_in, data_o1, data_o2, valid_o1, valid_o2,
           last_o1, last_o2, pkt_done_o
  );

  modport master (
    output data_in, valid_in, ready_1, ready_2,
    input  ready_in, data_o1, data_o2, valid_o1, valid_o2,
           last_o1, last_o2, pkt_done_o
  );

endinterface

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO; head visible one cycle after a push into empty.
// Push is ignored when full and pop when empty; the head reads as zero while empty.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same address with differing wrap bits means the writer is a full lap ahead.
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_pair_stream_src.sv
// Splits an interleaved word stream into two FWFT operand lanes with per-lane packet framing.
// Latency 1 into an empty lane; input stalls whenever the currently selected lane is full.
module fifo_pair_stream_src
  import fifo_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int AMOUNT_OF_DATA = 16,
  parameter int DEPTH          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_pair_stream_src_if.slave  s
);

  localparam int             CW        = $clog2(AMOUNT_OF_DATA);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(AMOUNT_OF_DATA - 1);

  lane_t         sel;
  logic          out_en;
  logic          full1, full2, empty1, empty2;
  logic          acc, push1, push2, pop1, pop2;
  logic          done1, done2;
  logic [CW-1:0] cnt1, cnt2;
  done_state_t   st, st_nxt;
  logic          pulse_nxt;

  // out_en keeps the input closed for the first cycle after reset release.
  assign s.ready_in = out_en && ((sel == LANE_1) ? !full1 : !full2);
  assign acc        = s.valid_in && s.ready_in;
  assign push1      = acc && (sel == LANE_1);
  assign push2      = acc && (sel == LANE_2);
  assign pop1       = !empty1 && s.ready_1;
  assign pop2       = !empty2 && s.ready_2;

  assign s.valid_o1 = !empty1;
  assign s.valid_o2 = !empty2;
  assign s.last_o1  = !empty1 && (cnt1 == LAST_BEAT);
  assign s.last_o2  = !empty2 && (cnt2 == LAST_BEAT);
  assign done1      = pop1 && s.last_o1;
  assign done2      = pop2 && s.last_o2;

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .push     (push1),
    .push_dat (s.data_in),
    .pop      (pop1),
    .head_dat (s.data_o1),
    .full     (full1),
    .empty    (empty1)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane2 (
    .clk      (clk),
    .rst      (rst),
    .push     (push2),
    .push_dat (s.data_in),
    .pop      (pop2),
    .head_dat (s.data_o2),
    .full     (full2),
    .empty    (empty2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel    <= LANE_1;
      out_en <= 1'b0;
      cnt1   <= '0;
      cnt2   <= '0;
    end else begin
      out_en <= 1'b1;
      if (acc) sel <= (sel == LANE_1) ? LANE_2 : LANE_1;
      if (pop1) cnt1 <= (cnt1 == LAST_BEAT) ? '0 : cnt1 + 1'b1;
      if (pop2) cnt2 <= (cnt2 == LAST_BEAT) ? '0 : cnt2 + 1'b1;
    end
  end

  // A lane finishing again while already waiting on its partner stays in its DONE state.
  always_comb begin
    st_nxt    = st;
    pulse_nxt = 1'b0;
    case (st)
      WAIT_BOTH: begin
        if (done1 && done2) pulse_nxt = 1'b1;
        else if (done1)     st_nxt = DONE1;
        else if (done2)     st_nxt = DONE2;
      end
      DONE1: begin
        if (done2) begin
          pulse_nxt = 1'b1;
          st_nxt    = done1 ? DONE1 : WAIT_BOTH;
        end
      end
      DONE2: begin
        if (done1) begin
          pulse_nxt = 1'b1;
          st_nxt    = done2 ? DONE2 : WAIT_BOTH;
        end
      end
      default: st_nxt = WAIT_BOTH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= WAIT_BOTH;
      s.pkt_done_o <= 1'b0;
    end else begin
      st           <= st_nxt;
      s.pkt_done_o <= pulse_nxt;
    end
  end

endmodule

// File: doc/fifo_pair_stream_src.md
FIFO_PAIR_STREAM_SRC -- requirements
Module: fifo_pair_stream_src

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of every data word.
REQ-002 The block SHALL have parameter AMOUNT_OF_DATA, default 16: word pairs per packet (>=2).
REQ-003 The block SHALL have parameter DEPTH, default 8: entries per lane FIFO (power of two, >=2).
REQ-004 The block SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have data_in  input  WIDTH  upstream interleaved word stream.
REQ-007 The block SHALL have valid_in  input  1  data_in valid.
REQ-008 The block SHALL have ready_in  output  1  block accepts data_in this cycle.
REQ-009 The block SHALL have data_o1 / data_o2  output  WIDTH  lane 1 / lane 2 operand words.
REQ-010 The block SHALL have valid_o1 / valid_o2  output  1  lane word valid.
REQ-011 The block SHALL have ready_1 / ready_2  input  1  downstream lane ready.
REQ-012 The block SHALL have last_o1 / last_o2  output  1  current lane word is the final word of its packet.
REQ-013 The block SHALL have pkt_done_o  output  1  one-cycle pulse when both lanes have completed a packet.

Function
REQ-014 Upstream word k of a packet SHALL route to lane 1 when k is even and lane 2 when k is odd; the lane select SHALL toggle only on an accepted word (valid_in & ready_in).
REQ-015 ready_in SHALL equal "selected lane FIFO not full"; a full selected lane SHALL stall input even if the other lane has space.
REQ-016 Each lane FIFO SHALL be first-word-fall-through; valid_oN = FIFO N not empty, data_oN = FIFO N head.
REQ-017 A lane word SHALL pop only on valid_oN & ready_N; lanes pop independently.
REQ-018 A word pushed into an empty FIFO SHALL appear on data_oN one cycle after acceptance (latency 1).
REQ-019 Simultaneous push and pop on a non-full lane SHALL keep the occupancy unchanged; on a full lane the push SHALL be blocked by ready_in (no bypass).
REQ-020 Read/write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty SHALL be decided from the MSB comparison.
REQ-021 Each lane SHALL hold a beat counter 0..AMOUNT_OF_DATA-1, incremented per pop and wrapping to 0 after AMOUNT_OF_DATA-1.
REQ-022 last_oN SHALL be high exactly when valid_oN is high and the lane N beat counter equals AMOUNT_OF_DATA-1.
REQ-023 A completion tracker SHALL be a three-state FSM: WAIT_BOTH -> (lane1 last pop only) DONE1 / (lane2 last pop only) DONE2 / (both in the same cycle) pulse pkt_done_o and stay WAIT_BOTH; DONE1 -> WAIT_BOTH on lane2 last pop with pulse; DONE2 symmetric.
REQ-024 pkt_done_o SHALL be registered and high for exactly one cycle per completed packet.
REQ-025 data_oN SHALL not change while valid_oN is high and ready_N is low.

Reset
REQ-026 Asserting rst low SHALL immediately empty both FIFOs, select lane 1, clear both beat counters, and enter WAIT_BOTH.
REQ-027 During and one cycle after reset: ready_in=0, valid_o1=valid_o2=0, last_o1=last_o2=0, pkt_done_o=0, data_o1=data_o2=0.
REQ-028 Reset mid-packet SHALL discard all buffered words; the next accepted word SHALL be word 0 of a new packet on lane 1.

Structure
REQ-029 Package fifo_pkg SHALL hold the lane-select typedef (LANE_1, LANE_2), the completion FSM state typedef, and the pointer-width function.
REQ-030 One sub-module fifo_sync (single-clock FWFT FIFO, WIDTH/DEPTH parameters, full/empty outputs) SHALL be instantiated once per lane.

Verification
REQ-031 Stream 1..32 with ready_1=ready_2=1 -> lane 1 yields 1,3,..,31, lane 2 yields 2,4,..,32; last_o1 on 31, last_o2 on 32; one pkt_done_o pulse.
REQ-032 ready_2=0, stream 20 words, DEPTH=8 -> ready_in drops after the 16th word (lane 2 full); lane 1 holds 8; releasing ready_2 resumes input with no loss or reorder.
REQ-033 Lane 1 drains a full packet while ready_2=0 -> FSM in DONE1, no pulse; then ready_2=1 -> pkt_done_o pulses once the cycle lane 2 pops its 16th word.
REQ-034 Sustained push/pop on both lanes at occupancy 1 for 3 packets -> pointers wrap past 2*DEPTH, output order exact, 3 pulses.
REQ-035 Assert rst after 5 accepted words -> all valids 0 the same cycle; after release, word 0xA5 appears on lane 1 with last_o1=0.
